// File: rtl/write_back_register_file.sv
// Register file for GPRs, CR fields and XER/LR/CTR with reservation-station busy/tag tracking.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write-back data and busy-clear onto the read ports.
module write_back_register_file #(
    parameter int RS_ID_WIDTH    = 5,
    parameter int GPR_READ_PORTS = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        gpr_reserve_valid,
    input  logic [4:0]                                  gpr_reserve_addr,
    input  logic [RS_ID_WIDTH-1:0]                      gpr_reserve_rs_id,
    input  logic                                        cr_reserve_valid,
    input  logic [0:7]                                  cr_reserve_enable,
    input  logic [RS_ID_WIDTH-1:0]                      cr_reserve_rs_id,
    input  logic                                        gpr_wb_valid,
    input  logic [RS_ID_WIDTH-1:0]                      gpr_wb_rs_id,
    input  logic [4:0]                                  gpr_wb_addr,
    input  logic [31:0]                                 gpr_wb_data,
    input  logic                                        spr_wb_valid,
    input  logic [9:0]                                  spr_wb_addr,
    input  logic [31:0]                                 spr_wb_data,
    input  logic                                        cr_wb_valid,
    input  logic [0:7][RS_ID_WIDTH-1:0]                 cr_wb_rs_id,
    input  logic [0:7]                                  cr_wb_enable,
    input  logic [0:31]                                 cr_wb_data,
    input  logic [0:GPR_READ_PORTS-1][4:0]              gpr_rd_addr,
    output logic [0:GPR_READ_PORTS-1][31:0]             gpr_rd_data,
    output logic [0:GPR_READ_PORTS-1]                   gpr_rd_busy,
    output logic [0:GPR_READ_PORTS-1][RS_ID_WIDTH-1:0]  gpr_rd_rs_id,
    output logic [0:31]                                 cr_rd_data,
    output logic [0:7]                                  cr_rd_busy,
    output logic [0:7][RS_ID_WIDTH-1:0]                 cr_rd_rs_id,
    input  logic [9:0]                                  spr_rd_addr,
    output logic [31:0]                                 spr_rd_data
);

    logic [31:0]            gpr_data [32];
    logic [RS_ID_WIDTH-1:0] gpr_tag  [32];
    logic [31:0]            gpr_busy, gpr_rsv, gpr_clr;
    logic [0:31]            cr_data;
    logic [0:7]             cr_busy, cr_rsv, cr_clr;
    logic [RS_ID_WIDTH-1:0] cr_tag [8];
    logic [31:0]            xer, lr, ctr;

    // A write-back only retires the entry it was issued for, and a same-cycle reservation wins.
    always_comb begin
        gpr_rsv = '0;
        gpr_clr = '0;
        cr_rsv  = '0;
        cr_clr  = '0;
        for (int i = 0; i < 32; i++) begin
            gpr_rsv[i] = gpr_reserve_valid && (gpr_reserve_addr == 5'(i));
            gpr_clr[i] = gpr_wb_valid && (gpr_wb_addr == 5'(i)) &&
                         (gpr_wb_rs_id == gpr_tag[i]) && !gpr_rsv[i];
        end
        for (int f = 0; f < 8; f++) begin
            cr_rsv[f] = cr_reserve_valid && cr_reserve_enable[f];
            cr_clr[f] = cr_wb_valid && cr_wb_enable[f] &&
                        (cr_wb_rs_id[f] == cr_tag[f]) && !cr_rsv[f];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_data[i] <= '0;
                gpr_tag[i]  <= '0;
            end
            for (int f = 0; f < 8; f++) cr_tag[f] <= '0;
            gpr_busy <= '0;
            cr_data  <= '0;
            cr_busy  <= '0;
            xer      <= '0;
            lr       <= '0;
            ctr      <= '0;
        end else begin
            if (gpr_wb_valid)      gpr_data[gpr_wb_addr]     <= gpr_wb_data;
            if (gpr_reserve_valid) gpr_tag[gpr_reserve_addr] <= gpr_reserve_rs_id;
            gpr_busy <= (gpr_busy & ~gpr_clr) | gpr_rsv;
            for (int f = 0; f < 8; f++) begin
                if (cr_wb_valid && cr_wb_enable[f]) cr_data[4*f +: 4] <= cr_wb_data[4*f +: 4];
                if (cr_rsv[f]) cr_tag[f] <= cr_reserve_rs_id;
            end
            cr_busy <= (cr_busy & ~cr_clr) | cr_rsv;
            if (spr_wb_valid) begin
                case (spr_wb_addr)
                    10'd1:   xer <= spr_wb_data;
                    10'd8:   lr  <= spr_wb_data;
                    10'd9:   ctr <= spr_wb_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < GPR_READ_PORTS; p++) begin
            gpr_rd_data[p]  = gpr_data[gpr_rd_addr[p]];
            gpr_rd_busy[p]  = gpr_busy[gpr_rd_addr[p]];
            gpr_rd_rs_id[p] = gpr_tag[gpr_rd_addr[p]];
`ifdef WB_REGFILE_BYPASS_EN
            if (gpr_wb_valid && (gpr_wb_addr == gpr_rd_addr[p])) gpr_rd_data[p] = gpr_wb_data;
            gpr_rd_busy[p] = gpr_busy[gpr_rd_addr[p]] & ~gpr_clr[gpr_rd_addr[p]];
`endif
        end
        cr_rd_data = cr_data;
        cr_rd_busy = cr_busy;
        for (int f = 0; f < 8; f++) begin
            cr_rd_rs_id[f] = cr_tag[f];
`ifdef WB_REGFILE_BYPASS_EN
            if (cr_wb_valid && cr_wb_enable[f]) cr_rd_data[4*f +: 4] = cr_wb_data[4*f +: 4];
`endif
        end
`ifdef WB_REGFILE_BYPASS_EN
        cr_rd_busy = cr_busy & ~cr_clr;
`endif
        case (spr_rd_addr)
            10'd1:   spr_rd_data = xer;
            10'd8:   spr_rd_data = lr;
            10'd9:   spr_rd_data = ctr;
            default: spr_rd_data = '0;
        endcase
`ifdef WB_REGFILE_BYPASS_EN
        if (spr_wb_valid && (spr_wb_addr == spr_rd_addr) &&
            (spr_rd_addr == 10'd1 || spr_rd_addr == 10'd8 || spr_rd_addr == 10'd9))
            spr_rd_data = spr_wb_data;
`endif
    end

endmodule

// File: tb/tb_write_back_register_file.sv
// Scoreboard bench for write_back_register_file: directed scenarios plus randomized traffic
// checked against an array/associative-array model of the register state.
module tb_write_back_register_file;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  gpr_reserve_valid;
    logic [4:0]            gpr_reserve_addr;
    logic [4:0]            gpr_reserve_rs_id;
    logic                  cr_reserve_valid;
    logic [0:7]            cr_reserve_enable;
    logic [4:0]            cr_reserve_rs_id;
    logic                  gpr_wb_valid;
    logic [4:0]            gpr_wb_rs_id;
    logic [4:0]            gpr_wb_addr;
    logic [31:0]           gpr_wb_data;
    logic                  spr_wb_valid;
    logic [9:0]            spr_wb_addr;
    logic [31:0]           spr_wb_data;
    logic                  cr_wb_valid;
    logic [0:7][4:0]       cr_wb_rs_id;
    logic [0:7]            cr_wb_enable;
    logic [0:31]           cr_wb_data;
    logic [0:2][4:0]       gpr_rd_addr;
    logic [0:2][31:0]      gpr_rd_data;
    logic [0:2]            gpr_rd_busy;
    logic [0:2][4:0]       gpr_rd_rs_id;
    logic [0:31]           cr_rd_data;
    logic [0:7]            cr_rd_busy;
    logic [0:7][4:0]       cr_rd_rs_id;
    logic [9:0]            spr_rd_addr;
    logic [31:0]           spr_rd_data;

    write_back_register_file #(.RS_ID_WIDTH(5), .GPR_READ_PORTS(3)) dut (
        .clk(clk), .rst(rst),
        .gpr_reserve_valid(gpr_reserve_valid), .gpr_reserve_addr(gpr_reserve_addr),
        .gpr_reserve_rs_id(gpr_reserve_rs_id),
        .cr_reserve_valid(cr_reserve_valid), .cr_reserve_enable(cr_reserve_enable),
        .cr_reserve_rs_id(cr_reserve_rs_id),
        .gpr_wb_valid(gpr_wb_valid), .gpr_wb_rs_id(gpr_wb_rs_id), .gpr_wb_addr(gpr_wb_addr),
        .gpr_wb_data(gpr_wb_data),
        .spr_wb_valid(spr_wb_valid), .spr_wb_addr(spr_wb_addr), .spr_wb_data(spr_wb_data),
        .cr_wb_valid(cr_wb_valid), .cr_wb_rs_id(cr_wb_rs_id), .cr_wb_enable(cr_wb_enable),
        .cr_wb_data(cr_wb_data),
        .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data), .gpr_rd_busy(gpr_rd_busy),
        .gpr_rd_rs_id(gpr_rd_rs_id),
        .cr_rd_data(cr_rd_data), .cr_rd_busy(cr_rd_busy), .cr_rd_rs_id(cr_rd_rs_id),
        .spr_rd_addr(spr_rd_addr), .spr_rd_data(spr_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            gr_v;  logic [4:0] gr_a; logic [4:0] gr_id;
        logic            cr_v;  logic [0:7] cr_en; logic [4:0] cr_id;
        logic            gw_v;  logic [4:0] gw_id; logic [4:0] gw_a; logic [31:0] gw_d;
        logic            sw_v;  logic [9:0] sw_a; logic [31:0] sw_d;
        logic            cw_v;  logic [0:7][4:0] cw_id; logic [0:7] cw_en; logic [0:31] cw_d;
        logic [0:2][4:0] rd_a;  logic [9:0] srd_a;
    } stim_t;

    typedef struct {
        logic [0:2][31:0] gd; logic [0:2] gb; logic [0:2][4:0] gt;
        logic [0:31] cd; logic [0:7] cb; logic [0:7][4:0] ct;
        logic [31:0] sd;
    } exp_t;

    // Reference state: one entry per architectural register / CR field.
    logic [31:0] m_gpr [32];
    bit          m_gbusy [32];
    logic [4:0]  m_gtag [32];
    logic [3:0]  m_cr [8];
    bit          m_cbusy [8];
    logic [4:0]  m_ctag [8];
    logic [31:0] m_spr [int];

    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] peek0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            int a = int'(s.rd_a[p]);
            e.gd[p] = m_gpr[a];
            e.gb[p] = m_gbusy[a];
            e.gt[p] = m_gtag[a];
`ifdef WB_REGFILE_BYPASS_EN
            if (s.gw_v && int'(s.gw_a) == a) begin
                e.gd[p] = s.gw_d;
                if (s.gw_id == m_gtag[a] && !(s.gr_v && int'(s.gr_a) == a)) e.gb[p] = 1'b0;
            end
`endif
        end
        for (int f = 0; f < 8; f++) begin
            e.cd[4*f +: 4] = m_cr[f];
            e.cb[f] = m_cbusy[f];
            e.ct[f] = m_ctag[f];
`ifdef WB_REGFILE_BYPASS_EN
            if (s.cw_v && s.cw_en[f]) begin
                e.cd[4*f +: 4] = s.cw_d[4*f +: 4];
                if (s.cw_id[f] == m_ctag[f] && !(s.cr_v && s.cr_en[f])) e.cb[f] = 1'b0;
            end
`endif
        end
        e.sd = m_spr.exists(int'(s.srd_a)) ? m_spr[int'(s.srd_a)] : 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (s.sw_v && s.sw_a == s.srd_a && m_spr.exists(int'(s.srd_a))) e.sd = s.sw_d;
`endif
        return e;
    endfunction

    task automatic model_update(stim_t s);
        if (!s.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_gpr[i] = 0; m_gbusy[i] = 0; m_gtag[i] = 0;
            end
            for (int f = 0; f < 8; f++) begin
                m_cr[f] = 0; m_cbusy[f] = 0; m_ctag[f] = 0;
            end
            m_spr[1] = 0; m_spr[8] = 0; m_spr[9] = 0;
        end else begin
            if (s.gw_v) begin
                m_gpr[s.gw_a] = s.gw_d;
                if (s.gw_id == m_gtag[s.gw_a] && !(s.gr_v && s.gr_a == s.gw_a)) m_gbusy[s.gw_a] = 0;
            end
            if (s.gr_v) begin
                m_gbusy[s.gr_a] = 1; m_gtag[s.gr_a] = s.gr_id;
            end
            for (int f = 0; f < 8; f++) begin
                if (s.cw_v && s.cw_en[f]) begin
                    m_cr[f] = s.cw_d[4*f +: 4];
                    if (s.cw_id[f] == m_ctag[f] && !(s.cr_v && s.cr_en[f])) m_cbusy[f] = 0;
                end
                if (s.cr_v && s.cr_en[f]) begin
                    m_cbusy[f] = 1; m_ctag[f] = s.cr_id;
                end
            end
            if (s.sw_v && m_spr.exists(int'(s.sw_a))) m_spr[int'(s.sw_a)] = s.sw_d;
        end
    endtask

    task automatic apply(stim_t s);
        rst = s.rst;
        gpr_reserve_valid = s.gr_v; gpr_reserve_addr = s.gr_a; gpr_reserve_rs_id = s.gr_id;
        cr_reserve_valid = s.cr_v; cr_reserve_enable = s.cr_en; cr_reserve_rs_id = s.cr_id;
        gpr_wb_valid = s.gw_v; gpr_wb_rs_id = s.gw_id; gpr_wb_addr = s.gw_a; gpr_wb_data = s.gw_d;
        spr_wb_valid = s.sw_v; spr_wb_addr = s.sw_a; spr_wb_data = s.sw_d;
        cr_wb_valid = s.cw_v; cr_wb_rs_id = s.cw_id; cr_wb_enable = s.cw_en; cr_wb_data = s.cw_d;
        gpr_rd_addr = s.rd_a; spr_rd_addr = s.srd_a;
    endtask

    // One clock: drive at negedge, queue the prediction, clock it in, then go idle.
    task automatic cyc(stim_t s, bit check = 1'b1);
        stim_t q;
        @(negedge clk);
        apply(s);
        if (check) sb_q.push_back(predict(s));
        #3 peek0 = gpr_rd_data[0];
        @(posedge clk);
        model_update(s);
        #1;
        q = idle();
        q.rd_a = s.rd_a;
        q.srd_a = s.srd_a;
        apply(q);
    endtask

    // Monitor: combinational read outputs are valid every cycle a prediction is queued.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                for (int p = 0; p < 3; p++) begin
                    chk($sformatf("gpr_rd_data[%0d]", p), 64'(gpr_rd_data[p]), 64'(e.gd[p]));
                    chk($sformatf("gpr_rd_busy[%0d]", p), 64'(gpr_rd_busy[p]), 64'(e.gb[p]));
                    chk($sformatf("gpr_rd_rs_id[%0d]", p), 64'(gpr_rd_rs_id[p]), 64'(e.gt[p]));
                end
                chk("cr_rd_data", 64'(cr_rd_data), 64'(e.cd));
                chk("cr_rd_busy", 64'(cr_rd_busy), 64'(e.cb));
                chk("cr_rd_rs_id", 64'(cr_rd_rs_id), 64'(e.ct));
                chk("spr_rd_data", 64'(spr_rd_data), 64'(e.sd));
            end
        end
    end

    initial begin
        stim_t s;
        logic [31:0] old1;
        apply(idle());
        s = idle(); s.rst = 1'b0;
        cyc(s, 1'b0);
        model_update(s);
        cyc(s);
        s = idle(); s.rd_a = '{5'd0, 5'd31, 5'd17}; s.srd_a = 10'd8;
        cyc(s);
        #2 chk("reset_gpr0", 64'(gpr_rd_data[0]), 64'h0);
        chk("reset_cr", 64'(cr_rd_data), 64'h0);

        // Reserve GPR5 tag 3, retire it with matching tag.
        s = idle(); s.rd_a = '{5'd5, 5'd5, 5'd5}; s.gr_v = 1; s.gr_a = 5; s.gr_id = 3;
        cyc(s);
        #2 chk("r5_busy_after_reserve", 64'(gpr_rd_busy[0]), 64'h1);
        s = idle(); s.rd_a = '{5'd5, 5'd5, 5'd5}; s.gw_v = 1; s.gw_a = 5; s.gw_id = 3; s.gw_d = 32'h12345678;
        cyc(s);
        #2 chk("r5_data", 64'(gpr_rd_data[0]), 64'h12345678);
        chk("r5_busy", 64'(gpr_rd_busy[0]), 64'h0);

        // Stale write-back to a re-reserved register keeps the newer producer pending.
        s = idle(); s.rd_a = '{5'd7, 5'd7, 5'd7}; s.gr_v = 1; s.gr_a = 7; s.gr_id = 2;
        cyc(s);
        s.gr_id = 9;
        cyc(s);
        s = idle(); s.rd_a = '{5'd7, 5'd7, 5'd7}; s.gw_v = 1; s.gw_a = 7; s.gw_id = 2; s.gw_d = 32'hAA;
        cyc(s);
        #2 chk("r7_data", 64'(gpr_rd_data[0]), 64'hAA);
        chk("r7_busy", 64'(gpr_rd_busy[0]), 64'h1);
        chk("r7_rs_id", 64'(gpr_rd_rs_id[0]), 64'h9);

        // Same-cycle reserve and write-back: reservation wins.
        s = idle(); s.rd_a = '{5'd4, 5'd4, 5'd4};
        s.gr_v = 1; s.gr_a = 4; s.gr_id = 6; s.gw_v = 1; s.gw_a = 4; s.gw_id = 6; s.gw_d = 32'h44;
        cyc(s);
        #2 chk("r4_busy", 64'(gpr_rd_busy[0]), 64'h1);
        chk("r4_rs_id", 64'(gpr_rd_rs_id[0]), 64'h6);

        // CR field 2 only, big-endian field numbering; SPR writes to unmapped address dropped.
        s = idle(); s.cw_v = 1; s.cw_en = 8'b0010_0000; s.cw_d = 32'hFFFFFFFF;
        s.sw_v = 1; s.sw_a = 10'd5; s.sw_d = 32'hDEADBEEF; s.srd_a = 10'd5;
        cyc(s);
        #2 chk("cr_field2", 64'(cr_rd_data), 64'h00F00000);
        chk("spr5_dropped", 64'(spr_rd_data), 64'h0);
        s = idle(); s.sw_v = 1; s.sw_a = 10'd8; s.sw_d = 32'hC0FFEE00; s.srd_a = 10'd8;
        cyc(s);
        #2 chk("spr_lr", 64'(spr_rd_data), 64'hC0FFEE00);

        // Read-during-write of GPR1.
        old1 = m_gpr[1];
        s = idle(); s.rd_a = '{5'd1, 5'd1, 5'd1}; s.gw_v = 1; s.gw_a = 1; s.gw_id = 0; s.gw_d = 32'h55;
        cyc(s);
`ifdef WB_REGFILE_BYPASS_EN
        chk("r1_same_cycle", 64'(peek0), 64'h55);
`else
        chk("r1_same_cycle", 64'(peek0), 64'(old1));
`endif
        #2 chk("r1_next_cycle", 64'(gpr_rd_data[0]), 64'h55);

        // Fill every GPR, reset for one cycle, confirm everything reads clean.
        for (int i = 0; i < 32; i++) begin
            s = idle(); s.gw_v = 1; s.gw_a = 5'(i); s.gw_id = 5'(i); s.gw_d = 32'hA000_0000 | i;
            s.gr_v = 1; s.gr_a = 5'(31 - i); s.gr_id = 5'(i); s.rd_a = '{5'(i), 5'(31 - i), 5'd0};
            cyc(s);
        end
        s = idle(); s.rst = 1'b0; s.gw_v = 1; s.gw_a = 3; s.gw_d = 32'h1; s.gr_v = 1; s.gr_a = 3;
        cyc(s);
        for (int i = 0; i < 32; i += 3) begin
            s = idle(); s.rd_a = '{5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32)};
            cyc(s);
            #2 chk($sformatf("post_reset_r%0d", i), 64'({gpr_rd_busy[0], gpr_rd_data[0]}), 64'h0);
        end

        // Randomized traffic; write-back tags often match the pending producer.
        for (int n = 0; n < 600; n++) begin
            s.rst   = ($urandom_range(0, 59) != 0);
            s.gr_v  = $urandom_range(0, 2) == 0;
            s.gr_a  = 5'($urandom);
            s.gr_id = 5'($urandom_range(0, 7));
            s.cr_v  = $urandom_range(0, 2) == 0;
            s.cr_en = 8'($urandom);
            s.cr_id = 5'($urandom_range(0, 7));
            s.gw_v  = $urandom_range(0, 1) == 1;
            s.gw_a  = 5'($urandom_range(0, 7));
            s.gw_id = $urandom_range(0, 1) ? m_gtag[s.gw_a] : 5'($urandom_range(0, 7));
            s.gw_d  = $urandom;
            s.sw_v  = $urandom_range(0, 1) == 1;
            s.sw_a  = $urandom_range(0, 1) ? 10'($urandom_range(0, 10)) : 10'($urandom);
            s.sw_d  = $urandom;
            s.cw_v  = $urandom_range(0, 1) == 1;
            s.cw_en = 8'($urandom);
            for (int f = 0; f < 8; f++)
                s.cw_id[f] = $urandom_range(0, 1) ? m_ctag[f] : 5'($urandom_range(0, 7));
            s.cw_d  = $urandom;
            for (int p = 0; p < 3; p++)
                s.rd_a[p] = (p == 0) ? s.gw_a : 5'($urandom_range(0, 7));
            s.srd_a = $urandom_range(0, 1) ? s.sw_a : 10'($urandom_range(0, 10));
            cyc(s);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
